// File: rtl/sat_engine_pkg.sv
// sat_engine_pkg: definitions shared by the variable-state array and its
// load/store sequencer.
package sat_engine_pkg;

  // Default width of one per-variable state word
  localparam int WIDTH_VAR_STATES_DEF = 17;

  // Load/store sequencer states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    LOAD_TAIL = 2'd2,
    STORE     = 2'd3
  } ldst_state_t;

endpackage

// File: rtl/var_state_ldst_if.sv
// var_state_ldst_if: control, BRAM and array-side signals of the load/store
// sequencer. The slave modport is the sequencer's view; the master modport is
// the view of whatever drives it.
interface var_state_ldst_if
  import sat_engine_pkg::*;
#(
  parameter int NUM_VARS         = 8,
  parameter int WIDTH_VAR_STATES = WIDTH_VAR_STATES_DEF,
  parameter int WIDTH_ADDR       = 9
) ();

  logic                                 start_load_i;
  logic                                 start_store_i;
  logic [WIDTH_ADDR-1:0]                base_addr_i;
  logic                                 busy_o;
  logic                                 done_o;
  logic [WIDTH_ADDR-1:0]                mem_addr_o;
  logic                                 mem_rd_o;
  logic [WIDTH_VAR_STATES-1:0]          mem_rdata_i;
  logic                                 mem_wr_o;
  logic [WIDTH_VAR_STATES-1:0]          mem_wdata_o;
  logic [NUM_VARS-1:0]                  wr_states_o;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i;

  modport slave (
    input  start_load_i, start_store_i, base_addr_i, mem_rdata_i, vars_states_i,
    output busy_o, done_o, mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o,
           wr_states_o, vars_states_o
  );

  modport master (
    output start_load_i, start_store_i, base_addr_i, mem_rdata_i, vars_states_i,
    input  busy_o, done_o, mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o,
           wr_states_o, vars_states_o
  );

endinterface

// File: rtl/var_ldst_shadow.sv
// var_ldst_shadow: keeps a copy of every word loaded into the variable-state
// array and reports whether a word about to be stored matches that copy.
// Only instantiated when VAR_LDST_SKIP_UNCHANGED_EN is defined.
module var_ldst_shadow #(
  parameter int NUM_VARS         = 8,
  parameter int WIDTH_VAR_STATES = 17,
  parameter int IW               = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_VARS-1:0]         i_wr_states,
  input  logic [WIDTH_VAR_STATES-1:0] i_wdata,
  input  logic [IW-1:0]               i_cmp_slot,
  input  logic [WIDTH_VAR_STATES-1:0] i_cmp_word,
  output logic                        o_same
);

  logic [WIDTH_VAR_STATES-1:0] r_shadow [NUM_VARS];

  // Capture each loaded word on the same edge the array captures it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VARS; i++) r_shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_VARS; i++) begin
        if (i_wr_states[NUM_VARS-1-i]) r_shadow[i] <= i_wdata;
        else                           r_shadow[i] <= r_shadow[i];
      end
    end
  end

  // Flag a store word that is identical to the last loaded copy of its slot
  always_comb begin
    o_same = 1'b0;
    if (r_shadow[i_cmp_slot] == i_cmp_word) o_same = 1'b1;
    else                                    o_same = 1'b0;
  end

endmodule

// File: rtl/var_state_ldst.sv
// var_state_ldst: load/store sequencer between the BRAM variable table and
// the engine's variable-state array. A load streams NUM_VARS words into the
// array with one-hot strobes; a store snapshots the array and writes it back.
// Optional feature: define VAR_LDST_SKIP_UNCHANGED_EN to suppress BRAM writes
// for slots whose word is unchanged since it was loaded.
module var_state_ldst
  import sat_engine_pkg::*;
#(
  parameter int NUM_VARS         = 8,
  parameter int WIDTH_VAR_STATES = WIDTH_VAR_STATES_DEF,
  parameter int WIDTH_ADDR       = 9
) (
  input  logic             clk,
  input  logic             rst,
  var_state_ldst_if.slave  bus
);

  localparam int CW = $clog2(NUM_VARS) + 1;
  localparam int IW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam logic [CW-1:0]       LAST = CW'(NUM_VARS - 1);
  localparam logic [NUM_VARS-1:0] ONE  = NUM_VARS'(1);

  ldst_state_t                          r_state;
  logic [CW-1:0]                        r_cnt;
  logic [WIDTH_ADDR-1:0]                r_addr;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] r_snap;
  logic                                 r_busy;
  logic                                 r_done;
  logic                                 r_rd;
  logic                                 r_wr;
  logic [WIDTH_VAR_STATES-1:0]          r_wdata;
  logic [NUM_VARS-1:0]                  r_wr_states;

  logic [CW-1:0]                        w_st_slot;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] w_st_src;
  logic [WIDTH_VAR_STATES-1:0]          w_st_word;
  logic                                 w_skip;

  // Slot and word the store path writes on the next edge (slot 0 comes
  // straight from the array on the start edge, later slots from the snapshot)
  always_comb begin
    w_st_slot = '0;
    w_st_src  = r_snap;
    if (r_state == IDLE) begin
      w_st_slot = '0;
      w_st_src  = bus.vars_states_i;
    end else if (r_cnt == LAST) begin
      w_st_slot = LAST;
      w_st_src  = r_snap;
    end else begin
      w_st_slot = r_cnt + CW'(1);
      w_st_src  = r_snap;
    end
    w_st_word = w_st_src[WIDTH_VAR_STATES*(NUM_VARS-int'(w_st_slot))-1 -: WIDTH_VAR_STATES];
  end

`ifdef VAR_LDST_SKIP_UNCHANGED_EN
  var_ldst_shadow #(
    .NUM_VARS         (NUM_VARS),
    .WIDTH_VAR_STATES (WIDTH_VAR_STATES),
    .IW               (IW)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .i_wr_states(r_wr_states),
    .i_wdata    (bus.mem_rdata_i),
    .i_cmp_slot (w_st_slot[IW-1:0]),
    .i_cmp_word (w_st_word),
    .o_same     (w_skip)
  );
`else
  assign w_skip = 1'b0;
`endif

  // Sequencer FSM: state, slot counter, address and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_snap      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_wr_states <= '0;
    end else begin
      r_done      <= 1'b0;
      r_wr_states <= '0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.start_load_i) begin
            r_state <= LOAD;
            r_addr  <= bus.base_addr_i;
            r_rd    <= 1'b1;
            r_busy  <= 1'b1;
          end else if (bus.start_store_i) begin
            r_state <= STORE;
            r_addr  <= bus.base_addr_i;
            r_snap  <= bus.vars_states_i;
            r_wr    <= ~w_skip;
            r_wdata <= w_st_word;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        LOAD: begin
          // Data for the read issued last cycle arrives now: strobe its slot
          r_wr_states <= ONE << (NUM_VARS - 1 - int'(r_cnt));
          if (r_cnt == LAST) begin
            r_state <= LOAD_TAIL;
            r_rd    <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_addr <= r_addr + WIDTH_ADDR'(1);
            r_rd   <= 1'b1;
          end
        end
        LOAD_TAIL: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        STORE: begin
          if (r_cnt == LAST) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_addr  <= r_addr + WIDTH_ADDR'(1);
            r_wr    <= ~w_skip;
            r_wdata <= w_st_word;
          end
        end
        default: begin
          r_state <= IDLE;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;
  assign bus.mem_addr_o    = r_addr;
  assign bus.mem_rd_o      = r_rd;
  assign bus.mem_wr_o      = r_wr;
  assign bus.mem_wdata_o   = r_wdata;
  assign bus.wr_states_o   = r_wr_states;
  // Every slot sees the read word; only the strobed slot captures it
  assign bus.vars_states_o = {NUM_VARS{bus.mem_rdata_i}};

endmodule

// File: tb/tb_var_state_ldst.sv
// tb_var_state_ldst: randomized self-checking bench for var_state_ldst with a
// behavioural BRAM, array and cycle-by-cycle expectation model.
module tb_var_state_ldst;

  localparam int N = 4;
  localparam int W = 17;
  localparam int A = 9;
`ifdef VAR_LDST_SKIP_UNCHANGED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic fill;
  logic pre_we;
  logic [A-1:0] pre_addr;
  logic [W-1:0] pre_data;

  logic [W-1:0] bram [0:511];
  logic [W-1:0] arr [N];
  logic [W-1:0] shadow_m [N];
  int n_checks = 0;
  int n_pass = 0;

  var_state_ldst_if #(.NUM_VARS(N), .WIDTH_VAR_STATES(W), .WIDTH_ADDR(A)) bus ();

  var_state_ldst #(.NUM_VARS(N), .WIDTH_VAR_STATES(W), .WIDTH_ADDR(A)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port BRAM with one-cycle read latency
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 512; i++) bram[i] <= W'(i * 97 + 12345);
    end else begin
      if (pre_we) bram[pre_addr] <= pre_data;
      if (bus.mem_wr_o) bram[bus.mem_addr_o] <= bus.mem_wdata_o;
    end
    if (bus.mem_rd_o) bus.mem_rdata_i <= bram[bus.mem_addr_o];
  end

  // Behavioural variable-state array: slot i captures on strobe bit N-1-i
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (bus.wr_states_o[N-1-i]) arr[i] <= bus.vars_states_o[W*(N-i)-1 -: W];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.start_load_i = 1'b0;
    bus.start_store_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic poke(input logic [A-1:0] a, input logic [W-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  function automatic logic [W*N-1:0] pack_arr();
    logic [W*N-1:0] r;
    for (int i = 0; i < N; i++) r[W*(N-i)-1 -: W] = arr[i];
    return r;
  endfunction

  // Load from base b; returns in the done cycle with starts low.
  // both: also raise start_store_i on the start edge; noise: random starts while busy.
  task automatic run_load(input logic [A-1:0] b, input bit both, input bit noise);
    logic [W-1:0] exp_w [N];
    logic [N-1:0] exp_strb;
    logic [A-1:0] ea;
    bit exp_rd, exp_busy, exp_done;
    for (int k = 0; k < N; k++) begin
      ea = b + A'(k);
      exp_w[k] = bram[ea];
    end
    bus.base_addr_i = b;
    bus.start_load_i = 1'b1;
    bus.start_store_i = both;
    tick();
    bus.start_load_i = 1'b0;
    bus.start_store_i = 1'b0;
    bus.base_addr_i = A'($urandom);
    for (int c = 1; c <= N + 2; c++) begin
      exp_rd = (c <= N);
      exp_busy = (c <= N + 1);
      exp_done = (c == N + 2);
      exp_strb = '0;
      if (c >= 2 && c <= N + 1) exp_strb[N-1-(c-2)] = 1'b1;
      n_checks++;
      if (bus.mem_rd_o !== exp_rd) $display("FAIL load_rd c%0d got %b want %b", c, bus.mem_rd_o, exp_rd);
      else n_pass++;
      n_checks++;
      if (bus.mem_wr_o !== 1'b0) $display("FAIL load_no_wr c%0d got %b want 0", c, bus.mem_wr_o);
      else n_pass++;
      n_checks++;
      if (bus.wr_states_o !== exp_strb) $display("FAIL load_strobe c%0d got %b want %b", c, bus.wr_states_o, exp_strb);
      else n_pass++;
      n_checks++;
      if (bus.busy_o !== exp_busy) $display("FAIL load_busy c%0d got %b want %b", c, bus.busy_o, exp_busy);
      else n_pass++;
      n_checks++;
      if (bus.done_o !== exp_done) $display("FAIL load_done c%0d got %b want %b", c, bus.done_o, exp_done);
      else n_pass++;
      if (exp_rd) begin
        ea = b + A'(c - 1);
        n_checks++;
        if (bus.mem_addr_o !== ea) $display("FAIL load_addr c%0d got %h want %h", c, bus.mem_addr_o, ea);
        else n_pass++;
      end
      if (c >= 2 && c <= N + 1) begin
        n_checks++;
        if (bus.vars_states_o[W*(N-(c-2))-1 -: W] !== exp_w[c-2])
          $display("FAIL load_data c%0d got %h want %h", c, bus.vars_states_o[W*(N-(c-2))-1 -: W], exp_w[c-2]);
        else n_pass++;
        shadow_m[c-2] = exp_w[c-2];
      end
      if (c < N + 2) begin
        if (noise) begin
          bus.start_load_i = 1'($urandom);
          bus.start_store_i = 1'($urandom);
        end
        tick();
        bus.start_load_i = 1'b0;
        bus.start_store_i = 1'b0;
      end
    end
  endtask

  // Store words to base b; returns in the done cycle with starts low.
  task automatic run_store(input logic [A-1:0] b, input logic [W*N-1:0] words, input bit noise);
    logic [W-1:0] snap [N];
    bit do_wr [N];
    logic [A-1:0] ea;
    bit exp_wr, exp_busy, exp_done;
    for (int k = 0; k < N; k++) begin
      snap[k] = words[W*(N-k)-1 -: W];
      do_wr[k] = !(SKIP && snap[k] == shadow_m[k]);
    end
    bus.vars_states_i = words;
    bus.base_addr_i = b;
    bus.start_store_i = 1'b1;
    tick();
    bus.start_store_i = 1'b0;
    bus.vars_states_i = {N{W'($urandom)}};
    bus.base_addr_i = A'($urandom);
    for (int c = 1; c <= N + 1; c++) begin
      exp_wr = (c <= N) && do_wr[(c <= N) ? c - 1 : 0];
      exp_busy = (c <= N);
      exp_done = (c == N + 1);
      n_checks++;
      if (bus.mem_wr_o !== exp_wr) $display("FAIL store_wr c%0d got %b want %b", c, bus.mem_wr_o, exp_wr);
      else n_pass++;
      n_checks++;
      if (bus.mem_rd_o !== 1'b0) $display("FAIL store_no_rd c%0d got %b want 0", c, bus.mem_rd_o);
      else n_pass++;
      n_checks++;
      if (bus.wr_states_o !== '0) $display("FAIL store_no_strobe c%0d got %b want 0", c, bus.wr_states_o);
      else n_pass++;
      n_checks++;
      if (bus.busy_o !== exp_busy) $display("FAIL store_busy c%0d got %b want %b", c, bus.busy_o, exp_busy);
      else n_pass++;
      n_checks++;
      if (bus.done_o !== exp_done) $display("FAIL store_done c%0d got %b want %b", c, bus.done_o, exp_done);
      else n_pass++;
      if (exp_wr) begin
        ea = b + A'(c - 1);
        n_checks++;
        if (bus.mem_addr_o !== ea) $display("FAIL store_addr c%0d got %h want %h", c, bus.mem_addr_o, ea);
        else n_pass++;
        n_checks++;
        if (bus.mem_wdata_o !== snap[c-1]) $display("FAIL store_wdata c%0d got %h want %h", c, bus.mem_wdata_o, snap[c-1]);
        else n_pass++;
      end
      if (c < N + 1) begin
        if (noise) begin
          bus.start_load_i = 1'($urandom);
          bus.start_store_i = 1'($urandom);
        end
        tick();
        bus.start_load_i = 1'b0;
        bus.start_store_i = 1'b0;
      end
    end
  endtask

  function automatic logic [W*N-1:0] rand_words();
    logic [W*N-1:0] r;
    for (int i = 0; i < N; i++) r[W*(N-i)-1 -: W] = W'($urandom);
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({bus.busy_o, bus.done_o, bus.mem_rd_o, bus.mem_wr_o} !== 4'b0000)
      $display("FAIL %s_ctrl got %b want 0000", tag, {bus.busy_o, bus.done_o, bus.mem_rd_o, bus.mem_wr_o});
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr_o, bus.mem_wdata_o, bus.wr_states_o} !== '0)
      $display("FAIL %s_data got %h/%h/%b want 0", tag, bus.mem_addr_o, bus.mem_wdata_o, bus.wr_states_o);
    else n_pass++;
  endtask

  task automatic test_reset;
    check_all_zero("reset");
  endtask

  task automatic test_load_basic;
    for (int i = 0; i < N; i++) poke(A'(9'h010 + i), W'(17'h1A000 + i));
    run_load(9'h010, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_store_basic;
    run_store(9'h020, rand_words(), 1'b0);
    idle(2);
  endtask

  task automatic test_wrap;
    run_store(9'h1FE, rand_words(), 1'b0);
    idle(1);
    run_load(9'h1FE, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_both_starts;
    run_load(A'($urandom), 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic test_busy_ignore;
    run_load(A'($urandom), 1'b0, 1'b1);
    idle(1);
    run_store(A'($urandom), rand_words(), 1'b1);
    idle(1);
  endtask

  task automatic test_back_to_back;
    run_load(A'($urandom), 1'b0, 1'b0);
    run_store(A'($urandom), rand_words(), 1'b0);
    run_load(A'($urandom), 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(1, 0) == 1) run_load(A'($urandom), 1'b0, 1'b0);
      else run_store(A'($urandom), rand_words(), 1'b0);
      idle($urandom_range(2, 0));
    end
  endtask

  task automatic test_reset_mid_load;
    logic [A-1:0] b;
    logic [W-1:0] exp0, keep1;
    b = A'($urandom);
    keep1 = arr[1];
    poke(b + A'(1), ~keep1);
    exp0 = bram[b];
    bus.base_addr_i = b;
    bus.start_load_i = 1'b1;
    tick();
    bus.start_load_i = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    n_checks++;
    if (arr[0] !== exp0) $display("FAIL midrst_slot0 got %h want %h", arr[0], exp0);
    else n_pass++;
    n_checks++;
    if (arr[1] !== keep1) $display("FAIL midrst_slot1 got %h want %h", arr[1], keep1);
    else n_pass++;
    rst = 1'b0;
    for (int k = 0; k < N; k++) shadow_m[k] = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.wr_states_o, bus.mem_rd_o, bus.busy_o} !== '0)
        $display("FAIL midrst_quiet got %b/%b/%b want 0", bus.wr_states_o, bus.mem_rd_o, bus.busy_o);
      else n_pass++;
    end
    run_load(A'($urandom), 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_skip_unchanged;
    logic [A-1:0] b;
    logic [W*N-1:0] words;
    b = A'($urandom);
    run_load(b, 1'b0, 1'b0);
    idle(1);
    words = pack_arr();
    words[W*(N-2)-1 -: W] = words[W*(N-2)-1 -: W] ^ W'(17'h00A5A);
    run_store(b, words, 1'b0);
    idle(1);
    run_store(b, pack_arr(), 1'b0);
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    fill = 1'b1;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus.start_load_i = 1'b0;
    bus.start_store_i = 1'b0;
    bus.base_addr_i = '0;
    bus.vars_states_i = '0;
    for (int k = 0; k < N; k++) shadow_m[k] = '0;
    tick();
    tick();
    fill = 1'b0;
    test_reset();
    rst = 1'b0;
    tick();
    test_load_basic();
    test_store_basic();
    test_wrap();
    test_both_starts();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid_load();
    test_skip_unchanged();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/var_state_ldst.md
# var_state_ldst

Load/store sequencer for the Sat Engine variable-state array. It moves per-variable state words between the single-port BRAM variable table and the engine's variable-state registers. A load reads NUM_VARS consecutive words and writes them into the array one slot per cycle with one-hot write strobes. A store snapshots the array and writes it back one word per cycle. It sits directly upstream (load path) and downstream (store path) of the variable-state array.

## Interface
- NUM_VARS, 8, variable slots in the engine array (≥2)
- WIDTH_VAR_STATES, 17, bits per variable state word (opaque to this block)
- WIDTH_ADDR, 9, BRAM word address width
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- start_load_i  in  1  request load from base_addr_i
- start_store_i  in  1  request store to base_addr_i
- base_addr_i  in  WIDTH_ADDR  table address of slot 0
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- mem_addr_o  out  WIDTH_ADDR  BRAM address
- mem_rd_o  out  1  BRAM read enable
- mem_rdata_i  in  WIDTH_VAR_STATES  BRAM read data, valid one cycle after mem_rd_o
- mem_wr_o  out  1  BRAM write enable
- mem_wdata_o  out  WIDTH_VAR_STATES  BRAM write data
- wr_states_o  out  NUM_VARS  one-hot slot write strobe to the array
- vars_states_o  out  WIDTH_VAR_STATES*NUM_VARS  state words to the array
- vars_states_i  in  WIDTH_VAR_STATES*NUM_VARS  state words from the array

## Operation
- Slot ordering:
  - Slot i occupies bits [WIDTH_VAR_STATES*(NUM_VARS-i)-1 -: WIDTH_VAR_STATES]; slot 0 is the MSB word.
  - Slot i's strobe is wr_states_o[NUM_VARS-1-i].
- States:
  - IDLE → LOAD on start_load_i.
  - IDLE → STORE on start_store_i.
  - LOAD → LOAD_TAIL after the last address is issued.
  - LOAD_TAIL → IDLE, pulsing done_o.
  - STORE → IDLE after the last write, pulsing done_o.
- Starts are sampled only in IDLE; starts while busy are ignored. If both starts are high together, the load wins and the store is dropped.
- On a start, base_addr_i is latched. A slot counter of $clog2(NUM_VARS)+1 bits is cleared.
- Address for slot i is (base + i) mod 2^WIDTH_ADDR, so it wraps silently.
- LOAD:
  - Issue mem_rd_o with addresses for slots 0..N-1 on consecutive cycles.
  - The cycle after each read, assert the matching strobe bit.
  - vars_states_o is mem_rdata_i replicated into every slot; only the strobed slot is captured by the array.
- STORE:
  - vars_states_i is snapshotted on the start edge.
  - Write slots 0..N-1 on consecutive cycles with mem_wr_o, mem_addr_o and mem_wdata_o = snapshot word.
- mem_rd_o and mem_wr_o are never asserted together.
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset mid-operation aborts immediately. No further strobes or writes occur; partially written slots keep their values.

## Timing
- Reference point: start accepted at edge 0; N = NUM_VARS.
- LOAD:
  - mem_rd_o high cycles 1..N.
  - wr_states_o strobe for slot k in cycle k+2.
  - busy_o high cycles 1..N+1.
  - done_o in cycle N+2, busy_o low.
- STORE:
  - mem_wr_o high cycles 1..N.
  - busy_o high cycles 1..N.
  - done_o in cycle N+1.
- Back-to-back: a start asserted in the done_o cycle is accepted.
- All outputs are registered except vars_states_o, which is combinational from mem_rdata_i.

## Configuration
- VAR_LDST_SKIP_UNCHANGED_EN defined:
  - A shadow copy of every word loaded is kept.
  - During STORE, mem_wr_o is suppressed for any slot whose snapshot equals its shadow.
  - The address still advances and cycle timing is unchanged.
  - The shadow is cleared to 0 by reset.
- Undefined: no shadow register; every slot is written on store.

## Structure
- Shared package sat_engine_pkg holds the following, used by the array and this block:
  - the FSM state enum (IDLE, LOAD, LOAD_TAIL, STORE);
  - the default WIDTH_VAR_STATES constant.
- One sub-module is natural: var_ldst_shadow, containing the shadow register and per-slot compare. It is instantiated only under VAR_LDST_SKIP_UNCHANGED_EN.

## Test plan
- Load, N=4, base 0x010, BRAM holds 0x1A000+i:
  - mem_rd_o cycles 1–4 at addresses 0x010–0x013.
  - wr_states_o = 1000, 0100, 0010, 0001 in cycles 2–5 with matching data.
  - done_o in cycle 6.
- Store, N=4, base 0x020, array holding words W0..W3:
  - Writes at 0x020–0x023 carry W0..W3 in cycles 1–4.
  - done_o in cycle 5.
  - Changing vars_states_i after cycle 0 has no effect.
- Wrap: store with base 0x1FE, N=4 → addresses 0x1FE, 0x1FF, 0x000, 0x001.
- Simultaneous start_load_i and start_store_i → load sequence only; no mem_wr_o.
- rst asserted in cycle 3 of a load → all outputs 0 asynchronously; no further strobes; the next start behaves normally.
- With VAR_LDST_SKIP_UNCHANGED_EN:
  - Load, then modify only slot 2, then store → mem_wr_o only in cycle 3 at base+2.
  - done_o still in cycle 5.
